// File: rtl/debug_pkg.sv
// Shared state encoding and defaults for the debug TX framer.
// The checksum states exist only when DEBUG_TX_CHECKSUM_EN is defined.
package debug_pkg;

    localparam logic [7:0] DEFAULT_HEADER    = 8'hA5;
    localparam int         DEFAULT_NUM_WORDS = 40;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_HDR        = 4'd1,
        ST_HDR_WAIT   = 4'd2,
        ST_FETCH      = 4'd3,
        ST_LOAD       = 4'd4,
        ST_SEND       = 4'd5,
        ST_WAIT       = 4'd6,
`ifdef DEBUG_TX_CHECKSUM_EN
        ST_CKSUM      = 4'd7,
        ST_CKSUM_WAIT = 4'd8,
`endif
        ST_DONE       = 4'd9
    } state_t;

endpackage

// File: rtl/byte_shifter.sv
// 32-bit word holder that presents its top byte and shifts left by one byte
// per request; last_byte marks the fourth byte of the loaded word.
module byte_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] din,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] shift_reg;
    logic [1:0]  idx_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            shift_reg <= din;
            idx_reg   <= 2'd0;
        end else if (shift) begin
            shift_reg <= {shift_reg[23:0], 8'h00};
            idx_reg   <= idx_reg + 2'd1;
        end
    end

    assign byte_out  = shift_reg[31:24];
    assign last_byte = (idx_reg == 2'd3);

endmodule

// File: rtl/debug_tx_framer.sv
// Frames a snapshot of debug words as header + MSB-first word bytes for the UART TX,
// one byte outstanding at a time. DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte.
module debug_tx_framer
    import debug_pkg::*;
#(
    parameter int         NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter logic [7:0] HEADER    = DEFAULT_HEADER,
    parameter int         ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] word_addr,
    input  logic [31:0]       word_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              idle,
    output logic              sentFlag,
    output logic [7:0]        sendCounter
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] word_idx_reg;
    logic [7:0]        count_reg;
    logic              sent_reg;
    logic [7:0]        shift_byte;
    logic              last_byte;
    logic              load;
    logic              shift;
    logic              last_word;
    logic              frame_begin;

    assign last_word   = (word_idx_reg == LAST_WORD);
    assign frame_begin = (state_reg == ST_IDLE) && start;

    byte_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .din       (word_data),
        .byte_out  (shift_byte),
        .last_byte (last_byte)
    );

`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] cksum_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cksum_reg <= '0;
        else if (frame_begin)
            cksum_reg <= '0;
        else if (tx_start)
            cksum_reg <= cksum_reg ^ tx_data;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_HDR;
            ST_HDR:      state_next = ST_HDR_WAIT;
            ST_HDR_WAIT: if (tx_done) state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_LOAD;
            ST_LOAD:     state_next = ST_SEND;
            ST_SEND:     state_next = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (!last_byte)
                        state_next = ST_SEND;
                    else if (!last_word)
                        state_next = ST_FETCH;
                    else
`ifdef DEBUG_TX_CHECKSUM_EN
                        state_next = ST_CKSUM;
`else
                        state_next = ST_DONE;
`endif
                end
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            ST_CKSUM:      state_next = ST_CKSUM_WAIT;
            ST_CKSUM_WAIT: if (tx_done) state_next = ST_DONE;
`endif
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_reg)
            ST_HDR: begin
                tx_start = 1'b1;
                tx_data  = HEADER;
            end
            ST_LOAD: load = 1'b1;
            ST_SEND: begin
                tx_start = 1'b1;
                tx_data  = shift_byte;
            end
            ST_WAIT: shift = tx_done && !last_byte;
`ifdef DEBUG_TX_CHECKSUM_EN
            ST_CKSUM: begin
                tx_start = 1'b1;
                tx_data  = cksum_reg;
            end
`endif
            default: ;
        endcase
    end

    // Word index holds through the whole word so the read port stays addressed; cleared on leaving DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx_reg <= '0;
            count_reg    <= '0;
            sent_reg     <= 1'b0;
        end else begin
            if (frame_begin) begin
                count_reg <= '0;
                sent_reg  <= 1'b0;
            end else if (tx_start) begin
                count_reg <= count_reg + 8'd1;
            end
            if (frame_begin || state_reg == ST_DONE)
                word_idx_reg <= '0;
            else if (state_reg == ST_WAIT && tx_done && last_byte && !last_word)
                word_idx_reg <= word_idx_reg + 1'b1;
            if (state_next == ST_DONE)
                sent_reg <= 1'b1;
        end
    end

    assign word_addr   = word_idx_reg;
    assign idle        = (state_reg == ST_IDLE);
    assign sentFlag    = sent_reg;
    assign sendCounter = count_reg;

endmodule

// File: doc/debug_tx_framer.md
# debug_tx_framer

Serializes a snapshot of datapath debug words (PC, registers, memory) into a byte-stream frame for the UART transmitter. It sits between the datapath's debug read port and the UART TX stage. On a start pulse it sends a header byte, then each 32-bit word MSB-first, then an optional XOR checksum. Each byte is handed to the UART TX and the next is held until that byte's done pulse. It drives `sentFlag` and `sendCounter` at the top level.

## Interface
- `NUM_WORDS`, default 40: words per frame, range 1..255.
- `HEADER`, default 8'hA5: frame start byte.
- `ADDR_W`, default 8: width of the word index.
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1: one-cycle request to send a frame.
- `word_addr`  out  ADDR_W: index of the word being read (0..NUM_WORDS-1).
- `word_data`  in  32: debug word; synchronous read, valid one cycle after `word_addr` changes.
- `tx_data`  out  8: byte for the UART TX.
- `tx_start`  out  1: one-cycle pulse; `tx_data` is valid in that cycle.
- `tx_done`  in  1: one-cycle pulse from the UART TX when the byte has left the line.
- `idle`  out  1: high in IDLE (drives `ledIdle`).
- `sentFlag`  out  1: sticky high after a complete frame; cleared by the next accepted `start`.
- `sendCounter`  out  8: bytes sent in the current or last frame.

## Operation
- States:
  - IDLE: waits for `start`.
  - HDR: issues `HEADER`, then waits for `tx_done`.
  - FETCH: sets `word_addr` and waits one cycle for `word_data`.
  - LOAD: latches `word_data` into a 32-bit shift register, byte index = 0.
  - SEND: issues `shift[31:24]`.
  - WAIT: waits for `tx_done`.
  - CKSUM: issues the checksum byte, then waits for `tx_done` (present only with the macro).
  - DONE: sets `sentFlag`, then returns to IDLE.
- IDLE -> HDR on `start`. On entry: clear `sentFlag`, `sendCounter` = 0, checksum = 0, word index = 0.
- HDR -> FETCH after `tx_done`.
- FETCH -> LOAD -> SEND -> WAIT.
- WAIT on `tx_done`:
  - byte index < 3: shift left by 8, increment the index, -> SEND.
  - else if word index < NUM_WORDS-1: increment the word index, -> FETCH.
  - else -> CKSUM, or DONE when the macro is off.
- Every issued byte increments `sendCounter` (modulo 256, wraps silently) in the `tx_start` cycle. The same byte is XORed into the checksum.
- `start` is ignored in every state except IDLE.
- `tx_done` is ignored in every state except HDR-wait, WAIT and CKSUM-wait.
- A spurious `tx_done` in any other state has no effect.
- `word_addr` stays stable from FETCH until the next FETCH. It is 0 in IDLE.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `word_addr`=0, `idle`=1, `sentFlag`=0, `sendCounter`=0, state IDLE.
- `start` sampled high at edge N -> `tx_start` high in cycle N+1, with `tx_data`=`HEADER`.
- A `tx_done` pulse at edge M -> the next `tx_start` follows:
  - at M+1 when the next byte is in the same word;
  - at M+3 when the next byte is the first byte of a new word (FETCH, LOAD, SEND).
- `tx_start` is never high in two consecutive cycles.
- At most one byte is outstanding at any time.
- After the final `tx_done`: `sentFlag` rises one cycle later (DONE), and `idle` rises the cycle after that.
- `start` arriving in the same cycle as the DONE -> IDLE transition is ignored.
- Reset asserted mid-frame: all outputs return to their reset values at once. A later `tx_done` for the aborted byte is ignored in IDLE.

## Configuration
- `DEBUG_TX_CHECKSUM_EN` defined:
  - CKSUM state exists.
  - The frame ends with the XOR of every preceding byte, header included.
  - Frame length is 4·NUM_WORDS+2 bytes.
- Not defined:
  - No CKSUM state and no checksum register.
  - WAIT goes straight to DONE after the last word.
  - Frame length is 4·NUM_WORDS+1 bytes.

## Structure
- Shared package `debug_pkg`:
  - state encoding constants (IDLE..DONE);
  - the default header 8'hA5;
  - the default word count 40.
- One sub-module is natural: `byte_shifter`, the 32-bit load/shift-by-8 register with a 2-bit byte index and a `last_byte` flag.

## Test plan
- NUM_WORDS=2, words 0x12345678 and 0xDEADBEEF, `tx_done` 5 cycles after each `tx_start`, macro on -> bytes A5 12 34 56 78 DE AD BE EF 8F; `sendCounter`=10; `sentFlag`=1; `idle`=1.
- Same stimulus with the macro off -> bytes A5 12 34 56 78 DE AD BE EF; `sendCounter`=9; no checksum byte.
- `start` pulsed again while in WAIT -> frame unchanged; exactly one header byte.
- Reset low during the 3rd byte -> `tx_start`=0, `sendCounter`=0, `sentFlag`=0, `idle`=1. The aborted byte's `tx_done` causes no output. A new `start` sends A5 first.
- NUM_WORDS=64 -> 258 bytes are sent; `sendCounter` wraps to 2; the final `word_addr` is 63.
- Second `start` after a completed frame -> `sentFlag` drops to 0 in the cycle after `start`; `sendCounter` restarts at 1 on the header.
